// File: rtl/muldiv_if.sv
// Handshake bundle for the RV32M multiply/divide unit.
// master: execute-stage issue/consume side; slave: the muldiv_unit engine.
interface muldiv_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 3
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// One bit per cycle: shift-add multiply or restoring divide on magnitudes, sign fixed at the end.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish in one cycle on zero multiply operands
// and on divides with |a| < |b|.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 3,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [OP_WIDTH-1:0] OpMulh   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OpMulhsu = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OpDiv    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OpRem    = OP_WIDTH'(6);

  localparam logic [DATA_WIDTH-1:0] MinNeg  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  CntLast = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]              r_state, w_state_nxt;
  logic [OP_WIDTH-1:0]     r_op, w_op_nxt;
  logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_nxt;
  // Multiply: {hi, lo=multiplier}; divide: {remainder, quotient/dividend}.
  logic [2*DATA_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [DATA_WIDTH-1:0]   r_opb, w_opb_nxt;
  logic                    r_negq, w_negq_nxt;
  logic                    r_negr, w_negr_nxt;
  logic [DATA_WIDTH-1:0]   r_result, w_result_nxt;

  logic                    w_is_div, w_is_rem;
  logic                    w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [DATA_WIDTH-1:0]   w_abs_a, w_abs_b;
  logic                    w_b_zero, w_ovf, w_early, w_fast;
  logic [DATA_WIDTH-1:0]   w_fast_res;
  logic [DATA_WIDTH:0]     w_mul_sum;
  logic [DATA_WIDTH+1:0]   w_div_diff;
  logic [2*DATA_WIDTH-1:0] w_mul_step, w_div_step, w_acc_step, w_prod_s;
  logic [DATA_WIDTH-1:0]   w_quo, w_rem, w_final;

  // Operand decode at issue
  assign w_is_div   = bus.op[2];
  assign w_is_rem   = bus.op[1];
  assign w_a_signed = (bus.op == OpMulh) || (bus.op == OpMulhsu) ||
                      (bus.op == OpDiv)  || (bus.op == OpRem);
  assign w_b_signed = (bus.op == OpMulh) || (bus.op == OpDiv) || (bus.op == OpRem);
  assign w_a_neg    = w_a_signed & bus.a[DATA_WIDTH-1];
  assign w_b_neg    = w_b_signed & bus.b[DATA_WIDTH-1];
  assign w_abs_a    = w_a_neg ? (-bus.a) : bus.a;
  assign w_abs_b    = w_b_neg ? (-bus.b) : bus.b;
  assign w_b_zero   = (bus.b == '0);
  assign w_ovf      = w_b_signed && w_is_div && (bus.a == MinNeg) && (bus.b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = w_is_div ? (w_abs_a < w_abs_b) : ((bus.a == '0) || (bus.b == '0));
`else
  assign w_early = 1'b0;
`endif

  assign w_fast = (w_is_div && (w_b_zero || w_ovf)) || w_early;

  // One-cycle results: divide by zero, signed overflow, early-outs
  always_comb begin
    w_fast_res = '0;
    if (w_is_div) begin
      if (w_b_zero)   w_fast_res = w_is_rem ? bus.a : '1;
      else if (w_ovf) w_fast_res = w_is_rem ? '0 : bus.a;
      else            w_fast_res = w_is_rem ? bus.a : '0;
    end
  end

  // Single iteration of shift-add multiply and restoring divide
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};
  assign w_div_diff = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]} -
                      {2'b00, r_opb};
  // Remainder MSB is always clear when restoring, so dropping it on the shift is safe.
  assign w_div_step = w_div_diff[DATA_WIDTH+1] ? {r_acc[2*DATA_WIDTH-2:0], 1'b0} :
                      {w_div_diff[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b1};
  assign w_acc_step = r_op[2] ? w_div_step : w_mul_step;

  // Sign correction and half/quotient/remainder select on the final iteration
  assign w_prod_s = r_negq ? (-w_acc_step) : w_acc_step;
  assign w_quo    = r_negq ? (-w_acc_step[DATA_WIDTH-1:0]) : w_acc_step[DATA_WIDTH-1:0];
  assign w_rem    = r_negr ? (-w_acc_step[2*DATA_WIDTH-1:DATA_WIDTH]) :
                    w_acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_final  = r_op[2] ? (r_op[1] ? w_rem : w_quo) :
                    ((r_op[1:0] == 2'b00) ? w_prod_s[DATA_WIDTH-1:0] :
                     w_prod_s[2*DATA_WIDTH-1:DATA_WIDTH]);

  // Next-state: flush dominates, then IDLE/CALC/DONE sequencing
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_opb_nxt    = r_opb;
    w_negq_nxt   = r_negq;
    w_negr_nxt   = r_negr;
    w_result_nxt = r_result;
    if (bus.flush) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            w_op_nxt   = bus.op;
            w_cnt_nxt  = '0;
            w_negq_nxt = w_a_neg ^ w_b_neg;
            w_negr_nxt = w_a_neg;
            if (w_fast) begin
              w_result_nxt = w_fast_res;
              w_state_nxt  = StDone;
            end else begin
              w_state_nxt = StCalc;
              if (w_is_div) begin
                w_acc_nxt = {{DATA_WIDTH{1'b0}}, w_abs_a};
                w_opb_nxt = w_abs_b;
              end else begin
                w_acc_nxt = {{DATA_WIDTH{1'b0}}, w_abs_b};
                w_opb_nxt = w_abs_a;
              end
            end
          end
        end
        StCalc: begin
          w_acc_nxt = w_acc_step;
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
          if (r_cnt == CntLast) begin
            w_result_nxt = w_final;
            w_state_nxt  = StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_opb    <= w_opb_nxt;
      r_negq   <= w_negq_nxt;
      r_negr   <= w_negr_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state != StIdle);
  assign bus.result    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (DATA_WIDTH=32).
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   rises;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EarlyLat = 1;
`else
  localparam int EarlyLat = 33;
`endif

  muldiv_if #(.DATA_WIDTH(32), .OP_WIDTH(3)) bus ();

  muldiv_unit #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for out_valid (bounded), check result/latency, hold, then consume.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat_exp,
                        input int hold);
    int lat;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.op        = o;
    bus.a         = x;
    bus.b         = y;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_res"}, bus.result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_res"}, bus.result, exp);
      chk({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply family
    run_op("mul_7x6",   3'b000, 32'd7,        32'd6,        32'd42,        33, 0);
    run_op("mulh_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("mul_lo_m1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33, 0);

    // Divide family
    run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2,   32'hFFFFFFFD, 33, 0);
    run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,   32'hFFFFFFFF, 33, 0);
    run_op("divu_100",  3'b101, 32'd100,      32'd7,   32'd14,       33, 0);
    run_op("remu_100",  3'b111, 32'd100,      32'd7,   32'd2,        33, 0);
    run_op("rem_7_m2",  3'b110, 32'd7, 32'hFFFFFFFE,   32'd1,        33, 0);

    // One-cycle special cases
    run_op("div_by0",   3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    run_op("rem_by0",   3'b110, 32'd5, 32'd0, 32'd5,        1, 0);
    run_op("divu_by0",  3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    // Early-out candidates: same results, latency depends on build
    run_op("mul_3x0",   3'b000, 32'd3, 32'd0,  32'd0, EarlyLat, 0);
    run_op("divu_3_10", 3'b101, 32'd3, 32'd10, 32'd0, EarlyLat, 0);
    run_op("remu_3_10", 3'b111, 32'd3, 32'd10, 32'd3, EarlyLat, 0);

    // Consumer back-pressure: result and ready held for 5 cycles
    run_op("mul_hold",  3'b000, 32'd7, 32'd6, 32'd42, 33, 5);

    // Flush mid-divide: back to IDLE next edge, result held, no out_valid
    bus.op        = 3'b100;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("flush_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_result_held", bus.result, 32'd42);
    rises = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) rises++;
    end
    chk("flush_no_valid", 32'(rises), 32'd0);

    // Flush in IDLE drops a simultaneous in_valid
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 3'b000;
    bus.a        = 32'd3;
    bus.b        = 32'd4;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_drop_busy", 32'(bus.busy), 32'd0);
    chk("flush_drop_in_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset mid-calculation
    bus.op       = 3'b000;
    bus.a        = 32'd9;
    bus.b        = 32'd9;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("arst_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unit operates normally after reset
    run_op("mul_post_rst", 3'b000, 32'd9, 32'd9, 32'd81, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
